// File: rtl/sir_uart_pkg.sv
// Shared types and constants for the SIR/UART transmitter (and the future receiver).
package sir_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } tx_state_t;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  localparam int unsigned TICKS_PER_BIT = 16;
  localparam logic [3:0]  SUB_LAST      = 4'(TICKS_PER_BIT - 1);

  localparam logic [3:0] SIR_PULSE_LO = 4'd7;
  localparam logic [3:0] SIR_PULSE_HI = 4'd9;

  // IrDA SIR: a zero bit is a 3/16 pulse centred in the bit, a one bit is silent.
  function automatic logic sir_level(input logic bit_val, input logic [3:0] sub);
    return !bit_val && (sub >= SIR_PULSE_LO) && (sub <= SIR_PULSE_HI);
  endfunction

endpackage

// File: rtl/sir_uart_tx_baud_tick_gen.sv
// Baud divider: counts 0..CLK_DIV-1 while enabled and pulses tick on the last count.
module baud_tick_gen #(
  parameter int unsigned CLK_DIV = 326
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int unsigned     CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Dropping enable clears the count so the next run starts phase-aligned.
  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = enable && (cnt == CNT_LAST);

endmodule

// File: rtl/sir_uart_tx.sv
// Parametrised async-frame serial transmitter with optional IrDA SIR line coding.
// Optional feature macro: SIR_IRDA_EN (3/16 pulse encoding selected by irda_mode).
module sir_uart_tx
  import sir_uart_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CLK_DIV   = 326,
  parameter int unsigned PARITY    = 1,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data_in,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              irda_mode,
  output logic              tx_out,
  output logic              busy
);

  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("sir_uart_tx: DATA_W must be in 5..9");
  end
  if (PARITY > PAR_ODD) begin : g_bad_parity
    $error("sir_uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("sir_uart_tx: STOP_BITS must be 1 or 2");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("sir_uart_tx: CLK_DIV must be at least 1");
  end

  localparam logic [3:0] IDX_DATA_LAST = 4'(DATA_W - 1);
  localparam logic [3:0] IDX_STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic       ODD_INV       = (PARITY == PAR_ODD);

  tx_state_t         state, state_n;
  logic [3:0]        sub, sub_n;
  logic [3:0]        idx, idx_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic              par_q;
  logic              ready_q;
  logic              busy_q;
  logic              line_q;
  logic              accept;
  logic              tick;
  logic              bit_n;
  logic              line_n;

  baud_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clock  (clock),
    .reset  (reset),
    .enable (state != IDLE),
    .tick   (tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    sub_n   = sub;
    idx_n   = idx;
    shreg_n = shreg;
    accept  = 1'b0;
    if (state == IDLE) begin
      if (tx_valid && ready_q) begin
        accept  = 1'b1;
        state_n = START;
        sub_n   = '0;
        idx_n   = '0;
        shreg_n = tx_data_in;
      end
    end else if (tick) begin
      sub_n = sub + 1'b1;
      if (sub == SUB_LAST) begin
        idx_n = idx + 1'b1;
        unique case (state)
          START: begin
            state_n = DATA;
            idx_n   = '0;
          end
          DATA: begin
            shreg_n = shreg >> 1;
            if (idx == IDX_DATA_LAST) begin
              idx_n   = '0;
              state_n = (PARITY == PAR_NONE) ? STOP : PAR;
            end
          end
          PAR: begin
            state_n = STOP;
            idx_n   = '0;
          end
          STOP: begin
            if (idx == IDX_STOP_LAST) begin
              idx_n   = '0;
              state_n = IDLE;
            end
          end
          default: state_n = IDLE;
        endcase
      end
    end
  end

  // Line level is computed from next-cycle state so the registered output
  // lines up with the state it describes (start edge one cycle after accept).
  always_comb begin
    bit_n = 1'b1;
    unique case (state_n)
      START:   bit_n = 1'b0;
      DATA:    bit_n = shreg_n[0];
      PAR:     bit_n = par_q;
      default: bit_n = 1'b1;
    endcase
  end

`ifdef SIR_IRDA_EN
  logic sir_q;
  logic sir_n;

  // In IDLE the live irda_mode sets the idle level; during a frame the captured copy rules.
  always_comb begin
    sir_n  = ((state == IDLE) || (state_n == IDLE)) ? irda_mode : sir_q;
    line_n = sir_n ? sir_level(bit_n, sub_n) : bit_n;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sir_q <= 1'b0;
    end else if (accept) begin
      sir_q <= irda_mode;
    end
  end
`else
  logic unused_irda;
  assign unused_irda = irda_mode;
  assign line_n      = bit_n;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      sub     <= '0;
      idx     <= '0;
      shreg   <= '0;
      par_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      line_q  <= 1'b1;
    end else begin
      sub     <= sub_n;
      idx     <= idx_n;
      shreg   <= shreg_n;
      ready_q <= (state_n == IDLE);
      busy_q  <= (state_n != IDLE);
      line_q  <= line_n;
      if (accept) begin
        par_q <= (^tx_data_in) ^ ODD_INV;
      end
    end
  end

  assign tx_ready = ready_q;
  assign busy     = busy_q;
  assign tx_out   = line_q;

endmodule

// File: doc/sir_uart_tx.md
# sir_uart_tx

Parametrised serial transmitter, the next generation of the fixed 8-bit IrDA transmitter in the UART/IrDA link. It takes words from the FIFO/sync stage over a valid/ready handshake and serialises them as asynchronous frames. Data width, parity, stop bits and baud divider are configurable. An optional IrDA SIR (3/16 pulse) line encoding is also available. It sits between `fifo_control`/`sync_data` and the physical TX pin.

## Interface
- `DATA_W`, 8, data bits per frame; legal range 5..9.
- `CLK_DIV`, 326, clock cycles per 1/16-bit tick; must be ≥1.
- `PARITY`, 1, parity mode: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1, number of stop bits; 1 or 2.
- `clock`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `tx_data_in`  in  DATA_W  word to send.
- `tx_valid`  in  1  `tx_data_in` is valid.
- `tx_ready`  out  1  block can accept a word; high only in IDLE.
- `irda_mode`  in  1  1 = SIR encoding; sampled at accept; ignored without `SIR_IRDA_EN`.
- `tx_out`  out  1  serial line, registered.
- `busy`  out  1  a frame is in progress; high in all states except IDLE.

## Operation
- **States:** IDLE → START → DATA → PAR → STOP → IDLE. PAR is skipped when `PARITY`=0.
- **Accept:** on `tx_valid && tx_ready`, capture the following:
  - the data word;
  - the parity bit: XOR of the data bits, inverted for odd parity;
  - `irda_mode`.
  Then go to START.
- **Tick divider:** counts 0..`CLK_DIV`-1 and emits a tick at `CLK_DIV`-1. It is held at 0 in IDLE, so the start bit is phase-aligned to the accept.
- **Bit timing:** each bit lasts 16 ticks. A 4-bit sub-tick counter runs 0..15 and advances the bit on wrap.
- **Bit order:** start bit = 0, then data bits LSB first (bit index counter 0..`DATA_W`-1), then parity, then `STOP_BITS`×16 ticks of stop level 1.
- **UART line coding:** `tx_out` equals the current bit value. Idle level is 1.
- **Mid-frame input changes:** `tx_data_in` and `irda_mode` changes during a frame are ignored. `tx_valid` in a non-IDLE state is not accepted; the producer holds it.
- **Reset:** reset in any state aborts the frame, discards the captured word, and clears all counters.
- **Reset values:** `tx_out`=1, `tx_ready`=0 during reset, `busy`=0, state=IDLE. `tx_ready` rises on the first cycle after reset is released.

## Timing
- **Latency:** the `tx_out` start edge appears one cycle after the accept cycle (registered output).
- **Frame length:** F = (1 + `DATA_W` + (`PARITY`≠0) + `STOP_BITS`) × 16 × `CLK_DIV` cycles.
- **IDLE gap:** STOP exits to IDLE. `tx_ready` is high for at least one cycle before the next accept. With `tx_valid` held high, back-to-back frame starts are F+1 cycles apart.
- **Handshake outputs:** `busy` rises the cycle after accept and falls in the same cycle `tx_ready` rises.
- **Reset timing:** a reset mid-frame returns `tx_out` to idle level on the cycle after reset is sampled.

## Configuration
- **Macro:** `SIR_IRDA_EN`.
- **With `SIR_IRDA_EN` defined and captured `irda_mode`=1:**
  - A bit value 0 drives `tx_out`=1 during sub-ticks 7..9 only, and 0 otherwise. This gives a 3/16 pulse centred in the bit.
  - A bit value 1 (including stop bits) drives 0 for the whole bit.
  - The line idles at 0. Once `irda_mode`=1 in IDLE, `tx_out` moves to 0 on the next cycle.
- **Without the macro:** `irda_mode` is unused, there is no SIR logic, and the output is plain UART.

## Structure
- **Shared package `sir_uart_pkg`:**
  - state enum `tx_state_t` (IDLE, START, DATA, PAR, STOP);
  - parity constants `PAR_NONE`/`PAR_EVEN`/`PAR_ODD`;
  - `TICKS_PER_BIT` = 16;
  - `SIR_PULSE_LO` = 7 and `SIR_PULSE_HI` = 9.
- **Sub-module `baud_tick_gen`:** parameter `CLK_DIV`, with an enable/clear input and a one-cycle `tick` output. It is reused by the future receiver.
- **Parameter checks:** illegal values of `DATA_W`, `PARITY` and `STOP_BITS` are caught at elaboration (assertion).

## Test plan
- **8E1 single frame:** `CLK_DIV`=1, 8E1, send 0xA5. `tx_out` = 0,1,0,1,0,0,1,0,1,0(parity),1 with each level held 16 cycles. The start edge comes one cycle after accept, and `tx_ready` returns after 176 cycles.
- **Parity modes:** `PARITY`=2, send 0x07 → parity bit 0. `PARITY`=1 → parity bit 1. `PARITY`=0 → 10-bit frame of 160 cycles.
- **Back-to-back frames:** `tx_valid` held high with 0x00 then 0xFF, `CLK_DIV`=2, 8N2. Accepts are exactly 353 cycles apart, and `busy` is low for exactly one cycle between frames.
- **Reset mid-frame:** reset asserted at the 5th data bit. Next cycle `tx_out`=1, `busy`=0; `tx_ready`=1 after release; the next frame is sent intact.
- **SIR encoding:** `SIR_IRDA_EN`, `irda_mode`=1, 8N1, `CLK_DIV`=1, send 0x00. Expect 9 high pulses, each 3 cycles wide, starting at cycle 7 of each bit period; stop and idle stay low.
- **SIR compiled out:** no macro, `irda_mode`=1, send 0x55. Output is an ordinary UART waveform that idles high.
